// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-clock divider, x/y counters shared with the
// tile renderers, and a registered output stage that keeps sync, blank and RGB aligned.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 2
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] counter_x,
    output logic [9:0] counter_y,
    output logic       pix_en,
    input  logic [7:0] red_in,
    input  logic [7:0] green_in,
    input  logic [7:0] blue_in,
    output logic       vga_clk,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       vga_sync_n,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       frame_start
);
    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int DIV_W    = $clog2(CLK_DIV);

    logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
    logic             pix_en_reg, vga_clk_reg;
    logic [9:0]       x_reg, y_reg, x_next, y_next;
    logic             hs_reg, vs_reg, blank_n_reg, frame_start_reg;
    logic             line_end, frame_end, hs_n, vs_n, visible;
    logic [7:0]       rgb_in  [3];
    logic [7:0]       rgb_reg [3];

    // Divider: pix_en and vga_clk are registered from the next divider value,
    // so pix_en is high exactly while div_cnt_reg sits at its terminal count.
    always_comb begin
        div_cnt_next = div_cnt_reg + 1'b1;
        if (div_cnt_reg == DIV_W'(CLK_DIV - 1))
            div_cnt_next = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_reg <= '0;
            pix_en_reg  <= 1'b0;
            vga_clk_reg <= 1'b0;
        end else begin
            div_cnt_reg <= div_cnt_next;
            pix_en_reg  <= (div_cnt_next == DIV_W'(CLK_DIV - 1));
            vga_clk_reg <= (div_cnt_next >= DIV_W'(CLK_DIV / 2));
        end
    end

    always_comb begin
        line_end  = (x_reg == 10'(H_TOTAL - 1));
        frame_end = (y_reg == 10'(V_TOTAL - 1));
        x_next    = line_end ? 10'd0 : x_reg + 10'd1;
        y_next    = y_reg;
        if (line_end)
            y_next = frame_end ? 10'd0 : y_reg + 10'd1;
        hs_n    = !((x_reg >= 10'(HS_START)) && (x_reg < 10'(HS_END)));
        vs_n    = !((y_reg >= 10'(VS_START)) && (y_reg < 10'(VS_END)));
        visible = (x_reg < 10'(H_VISIBLE)) && (y_reg < 10'(V_VISIBLE));
    end

    // Counters and the sync/blank stage share the pixel strobe, giving one pixel of latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_reg           <= '0;
            y_reg           <= '0;
            hs_reg          <= 1'b1;
            vs_reg          <= 1'b1;
            blank_n_reg     <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            frame_start_reg <= pix_en_reg && line_end && frame_end;
            if (pix_en_reg) begin
                x_reg       <= x_next;
                y_reg       <= y_next;
                hs_reg      <= hs_n;
                vs_reg      <= vs_n;
                blank_n_reg <= visible;
            end
        end
    end

    assign rgb_in[0] = red_in;
    assign rgb_in[1] = green_in;
    assign rgb_in[2] = blue_in;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_rgb
            always_ff @(posedge clk) begin
                if (rst)
                    rgb_reg[gi] <= 8'd0;
                else if (pix_en_reg)
                    rgb_reg[gi] <= visible ? rgb_in[gi] : 8'd0;
            end
        end
    endgenerate

    assign counter_x   = x_reg;
    assign counter_y   = y_reg;
    assign pix_en      = pix_en_reg;
    assign vga_clk     = vga_clk_reg;
    assign vga_hs      = hs_reg;
    assign vga_vs      = vs_reg;
    assign vga_blank_n = blank_n_reg;
    assign vga_sync_n  = 1'b0;
    assign vga_r       = rgb_reg[0];
    assign vga_g       = rgb_reg[1];
    assign vga_b       = rgb_reg[2];
    assign frame_start = frame_start_reg;
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

- Generates 640x480@60 Hz VGA raster timing from the 50 MHz system clock.
- Drives the shared `counter_x`/`counter_y` bus that the tile renderers decode into pixel colour.
- Registers the renderers' combinational RGB, gated by blanking, and drives the DAC/connector pins with sync aligned to pixel data.
- Sits at the top of the display path, between the board VGA pins and the tile/board renderers.

## Interface

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 2, system clocks per pixel (≥2)

Ports:
- clk  in  1  system clock, 50 MHz; one clock domain, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- counter_x  out  10  current pixel column, 0..H_TOTAL-1 (H_TOTAL=800)
- counter_y  out  10  current line, 0..V_TOTAL-1 (V_TOTAL=525)
- pix_en  out  1  one-clk strobe per pixel; counters and output regs update on it
- red_in / green_in / blue_in  in  8 each  renderer colour for current counters
- vga_clk  out  1  pixel clock to DAC, registered
- vga_hs  out  1  hsync, active low
- vga_vs  out  1  vsync, active low
- vga_blank_n  out  1  low during blanking
- vga_sync_n  out  1  constant 0 (no sync-on-green)
- vga_r / vga_g / vga_b  out  8 each  registered pixel colour
- frame_start  out  1  one-clk pulse at start of each frame

## Operation

- Divider `div_cnt` counts 0..CLK_DIV-1 and wraps.
  - `pix_en` is registered: high for the one clk cycle where `div_cnt` == CLK_DIV-1.
  - `vga_clk` is registered: high while `div_cnt` ≥ CLK_DIV/2.
- On `pix_en`:
  - `counter_x` increments.
  - At H_TOTAL-1, `counter_x` wraps to 0 and `counter_y` increments.
  - At (H_TOTAL-1, V_TOTAL-1), both counters wrap to 0.
  - Counters hold between strobes.
- Decode from current counters:
  - hs_n = 0 iff H_VISIBLE+H_FRONT ≤ x < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
  - vs_n = 0 iff V_VISIBLE+V_FRONT ≤ y < V_VISIBLE+V_FRONT+V_SYNC, i.e. 490..491.
  - visible = x < 640 && y < 480.
- Output stage, on the same `pix_en` edge: register hs_n, vs_n, visible→`vga_blank_n`, and RGB.
  - RGB is the `*_in` value when visible, else 0.
- `frame_start` is high for the one clk cycle after the `pix_en` edge on which the counters wrap to (0,0).
- Reset values:
  - counters 0, `div_cnt` 0
  - `pix_en` 0, `vga_clk` 0
  - `vga_hs` 1, `vga_vs` 1, `vga_blank_n` 0
  - RGB outputs 0, `frame_start` 0
- Reset does not generate `frame_start`.
- Reset mid-frame restarts at (0,0) on the next cycle. No partial-line recovery.

## Timing

- Renderer contract: `*_in` must be a valid combinational function of `counter_x`/`counter_y` by the next `pix_en`.
- Output latency is exactly one pixel (CLK_DIV clks). `vga_*` at pixel N reflect counters and RGB sampled at pixel N-1.
- Sync, blank and RGB outputs change only on the clk edge following a `pix_en` cycle, so all output pins are mutually aligned.
- Simultaneous `rst` and `pix_en`: reset wins.
- Line period = 800 pixels = 1600 clk. Frame period = 420000 pixels = 840000 clk.

## Test plan

- Reset: hold `rst` 3 clk.
  - Required: counters (0,0), `vga_hs`=`vga_vs`=1, `vga_blank_n`=0, RGB 0, `frame_start` 0.
  - After release: first `pix_en` on clk 2.
- Divider, CLK_DIV=2:
  - Required: `pix_en` high every 2nd clk; `vga_clk` 50% duty; `counter_x` 0→1→2 on successive strobes.
- Line wrap: run to `counter_x`=799, `counter_y`=5.
  - Required: next strobe gives (0,6); no `frame_start`.
- Sync windows: sample outputs over one frame.
  - Required: `vga_hs` low for exactly 96 pixels, corresponding to x 656..751 (outputs lagging by one pixel).
  - Required: `vga_vs` low for exactly 2 lines (1600 pixels), corresponding to y 490..491.
- Blank gating: drive `red_in`=8'hAE, `green_in`=8'h10, `blue_in`=8'hFF constant.
  - Required: `vga_r/g/b` = AE/10/FF for 640x480 pixels per frame; 0 with `vga_blank_n`=0 elsewhere.
  - Required: `frame_start` once per 840000 clk.
- Mid-frame reset: assert `rst` at (300,200) for 1 clk.
  - Required: counters (0,0) next cycle, outputs at reset values, normal timing resumes.
  - Required: next `frame_start` exactly 840000 clk after reset release plus divider phase.
